// File: rtl/reset_controller.sv
// Reset request controller: merges watchdog, software and external requests into a
// glitch-free, minimum-width active-low reset pulse and keeps sticky reset-cause flags.
module reset_controller #(
    parameter int          PULSE_CYCLES = 16,
    parameter int          GAP_CYCLES   = 4,
    parameter logic [7:0]  SW_KEY       = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wdt_rst_req,
    input  logic       ext_rst_req,
    input  logic       sw_rst_req,
    input  logic [7:0] sw_rst_key,
    input  logic       cause_clr,
    output logic       rst_out_n,
    output logic       rst_active,
    output logic [2:0] rst_cause,
    output logic       por_flag
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        HOLD     = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pending;
    logic [2:0]         r_pendVec;
    logic [2:0]         w_reqVec;
    logic               w_anyReq;
    logic               w_levelReq;
    logic               w_pendAny;
    logic               w_startPulse;

    // A software strobe only counts when it carries the right key.
    assign w_reqVec   = {ext_rst_req, sw_rst_req && (sw_rst_key == SW_KEY), wdt_rst_req};
    assign w_anyReq   = |w_reqVec;
    assign w_levelReq = ext_rst_req | wdt_rst_req;
    assign w_pendAny  = r_pending | w_anyReq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ASSERT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A request arriving on the last cooldown cycle is folded in so it is never dropped.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ASSERT;
                end
            end
            ASSERT: begin
                if (r_cnt == PULSE_LAST) begin
                    w_nextState = w_levelReq ? HOLD : COOLDOWN;
                end
            end
            HOLD: begin
                if (!w_levelReq) begin
                    w_nextState = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (r_cnt == GAP_LAST) begin
                    w_nextState = w_pendAny ? ASSERT : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        rst_active = (r_state == ASSERT) || (r_state == HOLD);
    end

    assign w_startPulse = (r_state == COOLDOWN) && (w_nextState == ASSERT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_nextState != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == ASSERT) || (r_state == COOLDOWN)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_pendVec <= 3'b000;
        end else if ((r_state == COOLDOWN) && !w_startPulse) begin
            r_pending <= w_pendAny;
            r_pendVec <= r_pendVec | w_reqVec;
        end else begin
            r_pending <= 1'b0;
            r_pendVec <= 3'b000;
        end
    end

    // Set bits always win over a coincident cause_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cause <= 3'b000;
            por_flag  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        rst_cause <= w_reqVec;
                        por_flag  <= 1'b0;
                    end else if (cause_clr) begin
                        rst_cause <= 3'b000;
                        por_flag  <= 1'b0;
                    end
                end
                ASSERT, HOLD: begin
                    rst_cause <= (cause_clr ? 3'b000 : rst_cause) | w_reqVec;
                    if (cause_clr) begin
                        por_flag <= 1'b0;
                    end
                end
                COOLDOWN: begin
                    if (w_startPulse) begin
                        rst_cause <= r_pendVec | w_reqVec;
                        por_flag  <= 1'b0;
                    end else if (cause_clr) begin
                        rst_cause <= 3'b000;
                        por_flag  <= 1'b0;
                    end
                end
                default: begin
                    rst_cause <= rst_cause;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_out_n <= 1'b0;
        end else begin
            rst_out_n <= !((w_nextState == ASSERT) || (w_nextState == HOLD));
        end
    end

endmodule
